// File: rtl/riscblade_pkg.sv
// Shared definitions for the riscblade 16-bit datapath.
// Holds the word type and the default reset vector.
package riscblade_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/program_counter.sv
// Program-counter register: loads on enable, resets to the reset vector.
// The increment adder lives in the datapath.
module program_counter
    import riscblade_pkg::*;
#(
    parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic  CLOCK,
    input  logic  RST,
    input  word_t PC_IN,
    input  logic  PC_EN,
    output word_t PC_OUT
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            PC_OUT <= RESET_VECTOR;
        end else if (PC_EN) begin
            PC_OUT <= PC_IN;
        end
    end

endmodule

// File: rtl/memory.sv
// Fetch/storage block: unified word memory with registered read plus the PC register.
// The memory port is independent of the PC; the datapath routes PC_OUT onto MEM_ADDR.
module memory
    import riscblade_pkg::*;
#(
    parameter int    ADDR_W       = 10,
    parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter        INIT_FILE    = ""
) (
    input  logic  CLOCK,
    input  logic  RST,
    input  word_t PC_IN,
    input  logic  PC_EN,
    output word_t PC_OUT,
    input  word_t MEM_ADDR,
    input  word_t MEM_DATA,
    input  logic  MEM_WRITE,
    output word_t MEM_OUT
);

    localparam int DEPTH = 2 ** ADDR_W;

    word_t             mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              unused_addr_bits;

    // Byte address to word index: bit 0 and bits above ADDR_W are dropped, so addresses alias.
    assign idx              = MEM_ADDR[ADDR_W:1];
    assign unused_addr_bits = ^(MEM_ADDR >> (ADDR_W + 1)) ^ MEM_ADDR[0];

    program_counter #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .CLOCK (CLOCK),
        .RST   (RST),
        .PC_IN (PC_IN),
        .PC_EN (PC_EN),
        .PC_OUT(PC_OUT)
    );

    // NOTE: the array has no reset so it maps to block RAM and keeps the program image across reset.
    always_ff @(posedge CLOCK) begin
        if (!RST && MEM_WRITE) begin
            mem[idx] <= MEM_DATA;
        end
    end

    // NOTE: reading the array in the same edge as the write returns the old word (read-before-write).
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            MEM_OUT <= '0;
        end else begin
            MEM_OUT <= mem[idx];
        end
    end

    // An unknown enable would otherwise be silently treated as "no write" / "hold".
    always_ff @(posedge CLOCK) begin
        if (!RST) begin
            assert (!$isunknown(MEM_WRITE)) else $error("memory: MEM_WRITE is unknown");
            assert (!$isunknown(PC_EN)) else $error("memory: PC_EN is unknown");
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed testbench for memory: PC load/hold, registered read, read-before-write,
// address aliasing and reset behaviour, checked against hand-computed values.
module tb_memory;
    import riscblade_pkg::*;

    logic  clk;
    logic  rst;
    word_t pc_in;
    logic  pc_en;
    word_t pc_out;
    word_t mem_addr;
    word_t mem_data;
    logic  mem_write;
    word_t mem_out;

    int checks = 0;
    int errors = 0;

    memory dut (
        .CLOCK    (clk),
        .RST      (rst),
        .PC_IN    (pc_in),
        .PC_EN    (pc_en),
        .PC_OUT   (pc_out),
        .MEM_ADDR (mem_addr),
        .MEM_DATA (mem_data),
        .MEM_WRITE(mem_write),
        .MEM_OUT  (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t observed, input word_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic we, input word_t addr, input word_t data);
        mem_write = we;
        mem_addr  = addr;
        mem_data  = data;
    endtask

    initial begin
        // 1. Reset wins over a PC load in the same cycle.
        rst   = 1'b1;
        pc_en = 1'b1;
        pc_in = 16'h1234;
        drive_mem(1'b0, 16'h0000, 16'h0000);
        tick();
        check("reset_pc", pc_out, 16'h0000);
        check("reset_mem_out", mem_out, 16'h0000);

        // 2. PC load then hold.
        rst   = 1'b0;
        pc_en = 1'b1;
        pc_in = 16'h0002;
        tick();
        check("pc_load", pc_out, 16'h0002);
        pc_en = 1'b0;
        pc_in = 16'hFFFF;
        tick();
        check("pc_hold", pc_out, 16'h0002);

        // 3. Write then read with one-edge latency.
        drive_mem(1'b1, 16'h0010, 16'hBEEF);
        tick();
        drive_mem(1'b0, 16'h0010, 16'h0000);
        tick();
        check("read_beef", mem_out, 16'hBEEF);

        // 4. Same-edge write and read returns old data.
        drive_mem(1'b1, 16'h0020, 16'hAAAA);
        tick();
        drive_mem(1'b1, 16'h0020, 16'h5555);
        tick();
        check("rbw_old", mem_out, 16'hAAAA);
        drive_mem(1'b0, 16'h0020, 16'h0000);
        tick();
        check("rbw_new", mem_out, 16'h5555);

        // 5. Aliasing: bit 0 ignored, bits above ADDR_W ignored.
        drive_mem(1'b1, 16'h0011, 16'h1111);
        tick();
        drive_mem(1'b0, 16'h0010, 16'h0000);
        tick();
        check("alias_bit0", mem_out, 16'h1111);
        drive_mem(1'b1, 16'h0810, 16'h2222);
        tick();
        drive_mem(1'b0, 16'h0010, 16'h0000);
        tick();
        check("alias_wrap_low", mem_out, 16'h2222);
        drive_mem(1'b0, 16'h8010, 16'h0000);
        tick();
        check("alias_wrap_high", mem_out, 16'h2222);
        check("pc_hold_during_mem", pc_out, 16'h0002);

        // Back-to-back writes then pipelined reads every cycle.
        drive_mem(1'b1, 16'h0100, 16'h0001);
        tick();
        drive_mem(1'b1, 16'h0102, 16'h0002);
        tick();
        drive_mem(1'b1, 16'h0104, 16'h0003);
        tick();
        drive_mem(1'b0, 16'h0100, 16'h0000);
        tick();
        check("b2b_read0", mem_out, 16'h0001);
        drive_mem(1'b0, 16'h0102, 16'h0000);
        tick();
        check("b2b_read1", mem_out, 16'h0002);
        drive_mem(1'b0, 16'h0104, 16'h0000);
        tick();
        check("b2b_read2", mem_out, 16'h0003);

        // 6. Reset drops only its own cycle's write; earlier contents persist.
        drive_mem(1'b1, 16'h0040, 16'hCAFE);
        tick();
        rst = 1'b1;
        drive_mem(1'b1, 16'h0040, 16'h0BAD);
        tick();
        check("rst_mid_mem_out", mem_out, 16'h0000);
        check("rst_mid_pc", pc_out, 16'h0000);
        rst = 1'b0;
        drive_mem(1'b0, 16'h0040, 16'h0000);
        tick();
        check("rst_keeps_cafe", mem_out, 16'hCAFE);
        drive_mem(1'b0, 16'h0010, 16'h0000);
        tick();
        check("rst_keeps_old", mem_out, 16'h2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
